// File: rtl/iomem_ctrl.sv
// iomem_ctrl: sequencing controller between the picosoc iomem master port and
// NSLOTS memory-mapped peripherals.
//
// Each access walks IDLE -> ACCESS -> RESP -> IDLE. In IDLE the address page
// addr[31:24] is decoded against BASE_PAGE..BASE_PAGE+NSLOTS-1. The request is
// then forwarded to the matching slave as a registered one-hot select, and the
// master receives a single-cycle m_ready pulse with the read data.
//
// An unmapped page still passes through ACCESS for one cycle, but with no
// slave selected. It completes with zero data, so it has the same two-cycle
// minimum latency as a mapped access and the CPU never hangs.
//
// Optional feature, macro IOMEM_CTRL_TIMEOUT_EN:
//   When defined, an 8-bit saturating counter runs in ACCESS. If the selected
//   slave has not answered by the time the counter reaches TIMEOUT, the access
//   is forced to complete with ERR_DATA and the sticky timeout_seen flag is
//   set. When undefined, ACCESS waits for s_ready indefinitely and
//   timeout_seen is tied low.
module iomem_ctrl #(
    parameter int          NSLOTS    = 4,
    parameter logic [7:0]  BASE_PAGE = 8'h03,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [3:0]             m_wstrb,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    output logic [31:0]            m_rdata,
    output logic [NSLOTS-1:0]      s_sel,
    output logic [3:0]             s_wstrb,
    output logic [23:0]            s_addr,
    output logic [31:0]            s_wdata,
    input  logic [NSLOTS-1:0]      s_ready,
    input  logic [NSLOTS*32-1:0]   s_rdata,
    output logic                   timeout_seen
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_reg;
    logic                m_ready_reg;
    logic [31:0]         m_rdata_reg;
    logic [NSLOTS-1:0]   s_sel_reg;
    logic [3:0]          s_wstrb_reg;
    logic [23:0]         s_addr_reg;
    logic [31:0]         s_wdata_reg;

    logic [NSLOTS-1:0]   page_hit;
    logic [31:0]         slot_rdata [NSLOTS];
    logic [31:0]         sel_rdata;
    logic                sel_ready;

`ifdef IOMEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0]          cnt_reg;
    logic                timeout_seen_reg;
`endif

    // Per-slot page decode and read-data gating by the registered select.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
            assign page_hit[gi]   = (m_addr[31:24] == BASE_PAGE + 8'(gi));
            assign slot_rdata[gi] = s_sel_reg[gi] ? s_rdata[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // Select is one-hot, so OR-ing the gated slot data is a plain mux.
    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < NSLOTS; i++) begin
            sel_rdata = sel_rdata | slot_rdata[i];
        end
    end

    // Only the ready bit of the currently selected slave counts.
    assign sel_ready = |(s_sel_reg & s_ready);

    // Access sequencer: decode, forward, wait, and issue the one-cycle response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            m_ready_reg <= 1'b0;
            m_rdata_reg <= 32'h0;
            s_sel_reg   <= '0;
            s_wstrb_reg <= 4'h0;
            s_addr_reg  <= 24'h0;
            s_wdata_reg <= 32'h0;
`ifdef IOMEM_CTRL_TIMEOUT_EN
            cnt_reg          <= 8'h0;
            timeout_seen_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    m_ready_reg <= 1'b0;
                    if (m_valid) begin
                        state_reg <= ST_ACCESS;
`ifdef IOMEM_CTRL_TIMEOUT_EN
                        cnt_reg   <= 8'h0;
`endif
                        if (|page_hit) begin
                            s_sel_reg   <= page_hit;
                            s_wstrb_reg <= m_wstrb;
                            s_addr_reg  <= m_addr[23:0];
                            s_wdata_reg <= m_wdata;
                        end else begin
                            // Unmapped: no slave selected, write dropped, reads return zero.
                            s_sel_reg   <= '0;
                            m_rdata_reg <= 32'h0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (s_sel_reg == '0) begin
                        state_reg   <= ST_RESP;
                        m_ready_reg <= 1'b1;
                    end else if (sel_ready) begin
                        m_rdata_reg <= sel_rdata;
                        s_sel_reg   <= '0;
                        state_reg   <= ST_RESP;
                        m_ready_reg <= 1'b1;
                    end
`ifdef IOMEM_CTRL_TIMEOUT_EN
                    else if (cnt_reg == TIMEOUT_CNT) begin
                        m_rdata_reg      <= ERR_DATA;
                        s_sel_reg        <= '0;
                        timeout_seen_reg <= 1'b1;
                        state_reg        <= ST_RESP;
                        m_ready_reg      <= 1'b1;
                    end else if (cnt_reg != 8'hFF) begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    m_ready_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    m_ready_reg <= 1'b0;
                    s_sel_reg   <= '0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready = m_ready_reg;
    assign m_rdata = m_rdata_reg;
    assign s_sel   = s_sel_reg;
    assign s_wstrb = s_wstrb_reg;
    assign s_addr  = s_addr_reg;
    assign s_wdata = s_wdata_reg;

`ifdef IOMEM_CTRL_TIMEOUT_EN
    assign timeout_seen = timeout_seen_reg;
`else
    // Timeout configuration has no effect in this build.
    logic unused_cfg;
    assign unused_cfg   = ^{ERR_DATA, 8'(TIMEOUT)};
    assign timeout_seen = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_ctrl.sv
// tb_iomem_ctrl: table-driven bench for iomem_ctrl (NSLOTS=4, BASE_PAGE=03,
// TIMEOUT=8). Expected read data and latency go into a scoreboard queue when a
// request is driven and are popped when m_ready is observed. Builds with or
// without IOMEM_CTRL_TIMEOUT_EN.
module tb_iomem_ctrl;

    localparam int NSLOTS = 4;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  m_valid = 1'b0;
    logic                  m_ready;
    logic [3:0]            m_wstrb = 4'h0;
    logic [31:0]           m_addr = 32'h0;
    logic [31:0]           m_wdata = 32'h0;
    logic [31:0]           m_rdata;
    logic [NSLOTS-1:0]     s_sel;
    logic [3:0]            s_wstrb;
    logic [23:0]           s_addr;
    logic [31:0]           s_wdata;
    logic [NSLOTS-1:0]     s_ready = '0;
    logic [NSLOTS*32-1:0]  s_rdata = '0;
    logic                  timeout_seen;

    iomem_ctrl #(
        .NSLOTS    (NSLOTS),
        .BASE_PAGE (8'h03),
        .TIMEOUT   (8),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .s_sel        (s_sel),
        .s_wstrb      (s_wstrb),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_ready      (s_ready),
        .s_rdata      (s_rdata),
        .timeout_seen (timeout_seen)
    );

    always #5 clk = ~clk;

    // One access: request fields, slave behaviour, and expected DUT response.
    // slot = -1 means unmapped; rdy_cyc = cycle the slave raises ready (0 = never).
    typedef struct {
        logic [31:0]       addr;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
        int                slot;
        int                rdy_cyc;
        bit                drop;
        logic [NSLOTS-1:0] exp_sel;
        logic [23:0]       exp_saddr;
        logic [3:0]        exp_swstrb;
        logic [31:0]       exp_swdata;
        logic [31:0]       sdata;
        logic [31:0]       exp_rdata;
        int                exp_lat;
        logic              exp_tos;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Random ready/data on every slot, with the addressed slot overridden.
    task automatic drive_slaves(input int slot, input bit rdy, input logic [31:0] data);
        s_ready = NSLOTS'($urandom());
        s_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (slot >= 0) begin
            s_ready[slot]          = rdy;
            s_rdata[32*slot +: 32] = data;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m_ready"},      32'(m_ready),      32'h0);
        chk({tag, "_s_sel"},        32'(s_sel),        32'h0);
        chk({tag, "_s_wstrb"},      32'(s_wstrb),      32'h0);
        chk({tag, "_s_addr"},       32'(s_addr),       32'h0);
        chk({tag, "_s_wdata"},      s_wdata,           32'h0);
        chk({tag, "_m_rdata"},      m_rdata,           32'h0);
        chk({tag, "_timeout_seen"}, 32'(timeout_seen), 32'h0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        exp_t              e;
        int                lat;
        bit                sel_bad;
        logic [NSLOTS-1:0] want_sel;
        @(negedge clk);
        // Cycle after a previous response: IDLE, so m_ready must be low again.
        chk({tag, "_ready_low_before"}, 32'(m_ready), 32'h0);
        m_valid = 1'b1;
        m_addr  = v.addr;
        m_wstrb = v.wstrb;
        m_wdata = v.wdata;
        sb.push_back('{v.exp_rdata, v.exp_lat});
        lat     = 0;
        sel_bad = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            want_sel = (c < v.exp_lat) ? v.exp_sel : '0;
            if (s_sel !== want_sel) sel_bad = 1'b1;
            if (c == 1) begin
                chk({tag, "_s_addr"},  32'(s_addr),  32'(v.exp_saddr));
                chk({tag, "_s_wstrb"}, 32'(s_wstrb), 32'(v.exp_swstrb));
                chk({tag, "_s_wdata"}, s_wdata,      v.exp_swdata);
            end
            if (v.drop && c == 2) m_valid = 1'b0;
            drive_slaves(v.slot, c == v.rdy_cyc, v.sdata);
            if (m_ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        m_valid = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            if (lat == 0) begin
                chk({tag, "_m_ready_missing"}, 32'h0, 32'h1);
            end else begin
                chk({tag, "_m_rdata"}, m_rdata, e.rdata);
                chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            end
        end
        chk({tag, "_timeout_seen"}, 32'(timeout_seen), 32'(v.exp_tos));
        chk({tag, "_s_sel_trace"},  32'(sel_bad),      32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cnt;
        bit idle_bad;

        // addr, wstrb, wdata, slot, rdy_cyc, drop, exp_sel, exp_saddr, exp_swstrb, exp_swdata, sdata, exp_rdata, lat, tos
        vecs.push_back('{32'h0300_0004, 4'h0, 32'h0000_0000,  0, 2, 1'b0, 4'b0001, 24'h000004, 4'h0, 32'h0000_0000, 32'h0000_00A5, 32'h0000_00A5,  3, 1'b0});
        vecs.push_back('{32'h0400_0010, 4'h2, 32'h0000_AB00,  1, 1, 1'b0, 4'b0010, 24'h000010, 4'h2, 32'h0000_AB00, 32'h1234_5678, 32'h1234_5678,  2, 1'b0});
        vecs.push_back('{32'h0900_0000, 4'hF, 32'hFFFF_FFFF, -1, 0, 1'b0, 4'b0000, 24'h000010, 4'h2, 32'h0000_AB00, 32'h0000_0000, 32'h0000_0000,  2, 1'b0});
        vecs.push_back('{32'h0600_FFFC, 4'h0, 32'h0000_0000,  3, 5, 1'b0, 4'b1000, 24'h00FFFC, 4'h0, 32'h0000_0000, 32'hC0FF_EE00, 32'hC0FF_EE00,  6, 1'b0});
        vecs.push_back('{32'h0500_0100, 4'hF, 32'h0102_0304,  2, 2, 1'b1, 4'b0100, 24'h000100, 4'hF, 32'h0102_0304, 32'h55AA_55AA, 32'h55AA_55AA,  3, 1'b0});
        vecs.push_back('{32'h0200_0000, 4'h0, 32'h0000_0000, -1, 0, 1'b0, 4'b0000, 24'h000100, 4'hF, 32'h0102_0304, 32'h0000_0000, 32'h0000_0000,  2, 1'b0});
        vecs.push_back('{32'h0700_0000, 4'h0, 32'h0000_0000, -1, 0, 1'b0, 4'b0000, 24'h000100, 4'hF, 32'h0102_0304, 32'h0000_0000, 32'h0000_0000,  2, 1'b0});
        vecs.push_back('{32'h0300_0008, 4'h0, 32'h0000_0000,  0, 1, 1'b0, 4'b0001, 24'h000008, 4'h0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D,  2, 1'b0});
        vecs.push_back('{32'h06AB_CDEF, 4'h0, 32'h0000_0000,  3, 3, 1'b0, 4'b1000, 24'hABCDEF, 4'h0, 32'h0000_0000, 32'h7654_3210, 32'h7654_3210,  4, 1'b0});
        vecs.push_back('{32'h0500_0000, 4'h0, 32'h0000_0000,  2, 9, 1'b0, 4'b0100, 24'h000000, 4'h0, 32'h0000_0000, 32'h1111_2222, 32'h1111_2222, 10, 1'b0});
`ifdef IOMEM_CTRL_TIMEOUT_EN
        vecs.push_back('{32'h0500_0040, 4'h0, 32'h0000_0000,  2, 0, 1'b0, 4'b0100, 24'h000040, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 10, 1'b1});
        vecs.push_back('{32'h0300_0000, 4'h0, 32'h0000_0000,  0, 1, 1'b0, 4'b0001, 24'h000000, 4'h0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0005,  2, 1'b1});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check_reset("reset");
        resetn = 1'b1;

        // Table: consecutive calls re-raise valid in the IDLE cycle after each response.
        foreach (vecs[i]) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
            $display("txn %0d addr=%h done m_rdata=%h", i, vecs[i].addr, m_rdata);
        end

`ifndef IOMEM_CTRL_TIMEOUT_EN
        // Without timeout: a silent slave holds the access forever.
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0500_0040;
        m_wstrb = 4'h0;
        ready_cnt = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            drive_slaves(2, 1'b0, 32'h0);
            if (m_ready === 1'b1) ready_cnt++;
        end
        chk("hang_no_ready", 32'(ready_cnt), 32'h0);
        chk("hang_sel_held", 32'(s_sel), 32'h4);
        m_valid = 1'b0;
        resetn  = 1'b0;
        #1;
        check_reset("hang_reset");
        @(negedge clk);
        resetn = 1'b1;
        $display("txn hang check done");
`endif

        // Reset asserted two cycles after s_sel rises.
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0400_0000;
        m_wstrb = 4'h0;
        @(negedge clk);
        drive_slaves(1, 1'b0, 32'h0);
        chk("rst_mid_sel_up", 32'(s_sel), 32'h2);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_sel_drop",   32'(s_sel),   32'h0);
        chk("rst_mid_ready_low",  32'(m_ready), 32'h0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst_mid");
        resetn = 1'b1;
        idle_bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_slaves(-1, 1'b0, 32'h0);
            if (m_ready !== 1'b0 || s_sel !== '0) idle_bad = 1'b1;
        end
        chk("rst_mid_idle_after", 32'(idle_bad), 32'h0);
        $display("txn reset-mid-access done");
        run_txn(vecs[0], "post_reset");
        $display("txn post-reset read done m_rdata=%h", m_rdata);

        @(negedge clk);
        chk("final_ready_low", 32'(m_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
